// File: rtl/nios_system_status_poller_pkg.sv
// Shared types and default constants for the status poller.
package nios_system_status_poller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAT   = 2'd2,
        GAP   = 2'd3
    } poll_state_t;

    localparam int DEF_POLL_PERIOD  = 16;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_TIMEOUT_CYC  = 64;

endpackage

// File: rtl/nios_system_status_poller_if.sv
// Avalon-MM read-only bus between the status poller (master) and a PIO slave.
interface nios_system_status_poller_if #(
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;

    modport master (
        output avm_address, avm_read,
        input  avm_waitrequest, avm_readdata
    );

    modport slave (
        input  avm_address, avm_read,
        output avm_waitrequest, avm_readdata
    );
endinterface

// File: rtl/nios_system_poll_timer.sv
// Loadable down-counter that holds at zero and reports a zero flag.
module nios_system_poll_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/nios_system_status_poller.sv
// Periodic Avalon-MM status poller with change/match flags.
// Optional waitrequest timeout enabled by defining STATUS_POLLER_TIMEOUT_EN.
module nios_system_status_poller
    import nios_system_status_poller_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int STATUS_W     = 2,
    parameter int POLL_ADDR    = 0,
    parameter int POLL_PERIOD  = DEF_POLL_PERIOD,
    parameter int READ_LATENCY = DEF_READ_LATENCY
`ifdef STATUS_POLLER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    nios_system_status_poller_if.master  avm,
    input  logic [STATUS_W-1:0]          match_value,
    output logic [STATUS_W-1:0]          status,
    output logic                         status_valid,
    output logic                         status_changed,
    output logic                         status_match,
    output logic                         timeout_err
);
    localparam int                 GAP_W    = $clog2(POLL_PERIOD + 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(POLL_PERIOD - 1);
    localparam logic [1:0]         LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    poll_state_t          state, next;
    logic [1:0]           lat_cnt;
    logic                 accept;
    logic                 sample;
    logic                 gap_zero;
    logic                 tmo_hit;
    logic [STATUS_W-1:0]  sample_bits;

    assign avm.avm_address = ADDR_W'(POLL_ADDR);
    assign avm.avm_read    = (state == ISSUE);
    assign accept          = (state == ISSUE) && !avm.avm_waitrequest;
    assign sample_bits     = avm.avm_readdata[STATUS_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next   = state;
        sample = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next = ISSUE;
            end
            ISSUE: begin
                if (accept) begin
                    if (READ_LATENCY == 0) begin
                        sample = 1'b1;
                        next   = enable ? GAP : IDLE;
                    end else begin
                        next = LAT;
                    end
                end else if (tmo_hit) begin
                    next = GAP;
                end
            end
            LAT: begin
                if (lat_cnt == 2'd0) begin
                    sample = 1'b1;
                    next   = enable ? GAP : IDLE;
                end
            end
            GAP: begin
                if (!enable) next = IDLE;
                else if (gap_zero) next = ISSUE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lat_cnt <= 2'd0;
        end else if (accept) begin
            lat_cnt <= LAT_LOAD;
        end else if ((state == LAT) && (lat_cnt != 2'd0)) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

    // Gap counter is reloaded on every entry so a short GAP visit never leaves residue.
    nios_system_poll_timer #(.W(GAP_W)) u_gap_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     ((state != GAP) && (next == GAP)),
        .load_val (GAP_LOAD),
        .dec      (state == GAP),
        .zero     (gap_zero)
    );

`ifdef STATUS_POLLER_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
    logic tmo_zero;

    nios_system_poll_timer #(.W(TMO_W)) u_tmo_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     ((state != ISSUE) && (next == ISSUE)),
        .load_val (TMO_LOAD),
        .dec      ((state == ISSUE) && avm.avm_waitrequest),
        .zero     (tmo_zero)
    );

    assign tmo_hit = tmo_zero;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout_err <= 1'b0;
        end else if ((state == ISSUE) && !accept && tmo_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            status         <= '0;
            status_valid   <= 1'b0;
            status_changed <= 1'b0;
        end else begin
            status_changed <= 1'b0;
            if (sample) begin
                status         <= sample_bits;
                status_valid   <= 1'b1;
                status_changed <= status_valid && (sample_bits != status);
            end
        end
    end

    assign status_match = status_valid && (status == match_value);
endmodule
